decode_wb_pipe: RTL and testbench

//  Parametrised Y86-64 decode stage with integrated register file and D->E pipeline register.

---
 rtl/decode_wb_pipe.sv | 168 ++++++++++++++++
 tb/tb_decode_wb_pipe.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/decode_wb_pipe.sv
// Y86-64 decode stage: register-id generation, 15-entry register file with W-stage
// writeback, optional e/M/W bypass network (DECODE_FWD_EN) and the D->E pipeline register.
module decode_wb_pipe #(
  parameter int                DATA_W   = 64,
  parameter int                NREG     = 15,
  parameter logic [DATA_W-1:0] RSP_INIT = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        D_icode,
  input  logic [3:0]        D_ifun,
  input  logic [3:0]        D_rA,
  input  logic [3:0]        D_rB,
  input  logic [DATA_W-1:0] D_valC,
  input  logic [DATA_W-1:0] D_valP,
  input  logic [1:0]        D_stat,
  input  logic              E_bubble,
  input  logic              E_stall,
  input  logic [3:0]        e_dstE,
  input  logic [DATA_W-1:0] e_valE,
  input  logic [3:0]        M_dstE,
  input  logic [DATA_W-1:0] M_valE,
  input  logic [3:0]        M_dstM,
  input  logic [DATA_W-1:0] m_valM,
  input  logic [3:0]        W_dstE,
  input  logic [DATA_W-1:0] W_valE,
  input  logic [3:0]        W_dstM,
  input  logic [DATA_W-1:0] W_valM,
  output logic [3:0]        d_srcA,
  output logic [3:0]        d_srcB,
  output logic [3:0]        E_icode,
  output logic [3:0]        E_ifun,
  output logic [1:0]        E_stat,
  output logic [DATA_W-1:0] E_valA,
  output logic [DATA_W-1:0] E_valB,
  output logic [DATA_W-1:0] E_valC,
  output logic [3:0]        E_dstE,
  output logic [3:0]        E_dstM,
  output logic [3:0]        E_srcA,
  output logic [3:0]        E_srcB
);

  localparam logic [3:0] RNONE  = 4'hF;
  localparam logic [3:0] RRSP   = 4'h4;
  localparam logic [3:0] INOP   = 4'h1;
  localparam logic [4:0] NREG_L = 5'(NREG);
  localparam logic [DATA_W-1:0] ZERO = {DATA_W{1'b0}};

  function automatic logic [3:0] srcAOf(input logic [3:0] icode, input logic [3:0] rA);
    case (icode)
      4'h2, 4'h4, 4'h6, 4'hA: srcAOf = rA;
      4'h9, 4'hB:             srcAOf = RRSP;
      default:                srcAOf = RNONE;
    endcase
  endfunction

  function automatic logic [3:0] srcBOf(input logic [3:0] icode, input logic [3:0] rB);
    case (icode)
      4'h4, 4'h5, 4'h6:       srcBOf = rB;
      4'h8, 4'h9, 4'hA, 4'hB: srcBOf = RRSP;
      default:                srcBOf = RNONE;
    endcase
  endfunction

  function automatic logic [3:0] dstEOf(input logic [3:0] icode, input logic [3:0] rB);
    case (icode)
      4'h2, 4'h3, 4'h6:       dstEOf = rB;
      4'h8, 4'h9, 4'hA, 4'hB: dstEOf = RRSP;
      default:                dstEOf = RNONE;
    endcase
  endfunction

  function automatic logic [3:0] dstMOf(input logic [3:0] icode, input logic [3:0] rA);
    case (icode)
      4'h5, 4'hB: dstMOf = rA;
      default:    dstMOf = RNONE;
    endcase
  endfunction

  function automatic logic regValid(input logic [3:0] id);
    regValid = (id != RNONE) && ({1'b0, id} < NREG_L);
  endfunction

  logic [3:0]                   srcA_s, srcB_s, dstE_s, dstM_s;
  logic [DATA_W-1:0]            rfA_s, rfB_s, opA_s, opB_s, valA_s;
  logic [NREG-1:0][DATA_W-1:0]  regFile_s;

  // Register ids derived from the instruction class
  always_comb begin
    srcA_s = srcAOf(D_icode, D_rA);
    srcB_s = srcBOf(D_icode, D_rB);
    dstE_s = dstEOf(D_icode, D_rB);
    dstM_s = dstMOf(D_icode, D_rA);
  end

  assign d_srcA = srcA_s;
  assign d_srcB = srcB_s;

  for (genvar g = 0; g < NREG; g++) begin : gReg
    localparam logic [3:0]        ID   = 4'(g);
    localparam logic [DATA_W-1:0] INIT = (g == int'(RRSP)) ? RSP_INIT : ZERO;
    logic [DATA_W-1:0] q_r;
    // One architectural register; the memory-result port wins when both target it
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q_r <= INIT;
      end else if (W_dstM == ID) begin
        q_r <= W_valM;
      end else if (W_dstE == ID) begin
        q_r <= W_valE;
      end
    end
    assign regFile_s[g] = q_r;
  end

  // Read ports see the pre-write contents; out-of-range ids read as zero
  always_comb begin
    rfA_s = regValid(srcA_s) ? regFile_s[srcA_s] : ZERO;
    rfB_s = regValid(srcB_s) ? regFile_s[srcB_s] : ZERO;
  end

`ifdef DECODE_FWD_EN
  // Bypass priority runs youngest to oldest so the newest producer wins
  always_comb begin
    opA_s = rfA_s;
    if (srcA_s == RNONE)       opA_s = rfA_s;
    else if (srcA_s == e_dstE) opA_s = e_valE;
    else if (srcA_s == M_dstM) opA_s = m_valM;
    else if (srcA_s == M_dstE) opA_s = M_valE;
    else if (srcA_s == W_dstM) opA_s = W_valM;
    else if (srcA_s == W_dstE) opA_s = W_valE;
    else                       opA_s = rfA_s;
    opB_s = rfB_s;
    if (srcB_s == RNONE)       opB_s = rfB_s;
    else if (srcB_s == e_dstE) opB_s = e_valE;
    else if (srcB_s == M_dstM) opB_s = m_valM;
    else if (srcB_s == M_dstE) opB_s = M_valE;
    else if (srcB_s == W_dstM) opB_s = W_valM;
    else if (srcB_s == W_dstE) opB_s = W_valE;
    else                       opB_s = rfB_s;
  end
`else
  logic unusedFwd_s;
  assign unusedFwd_s = ^{e_dstE, e_valE, M_dstE, M_valE, M_dstM, m_valM};
  assign opA_s = rfA_s;
  assign opB_s = rfB_s;
`endif

  // call/jXX carry the return address in valA
  always_comb begin
    if (D_icode == 4'h7 || D_icode == 4'h8) valA_s = D_valP;
    else                                    valA_s = opA_s;
  end

  // D->E pipeline register; bubble overrides stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || E_bubble) begin
      E_icode <= INOP;  E_ifun <= 4'h0;  E_stat <= 2'h0;
      E_valA  <= ZERO;  E_valB <= ZERO;  E_valC <= ZERO;
      E_dstE  <= RNONE; E_dstM <= RNONE; E_srcA <= RNONE; E_srcB <= RNONE;
    end else if (!E_stall) begin
      E_icode <= D_icode; E_ifun <= D_ifun; E_stat <= D_stat;
      E_valA  <= valA_s;  E_valB <= opB_s;  E_valC <= D_valC;
      E_dstE  <= dstE_s;  E_dstM <= dstM_s; E_srcA <= srcA_s; E_srcB <= srcB_s;
    end
  end

endmodule

// File: tb/tb_decode_wb_pipe.sv
// Self-checking bench for decode_wb_pipe: directed scenarios plus randomized traffic
// compared against a register-array reference model.
module tb_decode_wb_pipe;
  localparam logic [63:0]  RSP0 = 64'h0000_0000_0000_1000;
  localparam logic [217:0] NOPV = {4'h1, 4'h0, 2'h0, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF, 4'hF, 4'hF};

  logic        clk, rst_n;
  logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
  logic [63:0] D_valC, D_valP;
  logic [1:0]  D_stat;
  logic        E_bubble, E_stall;
  logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
  logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
  wire  [3:0]  d_srcA, d_srcB, E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
  wire  [1:0]  E_stat;
  wire  [63:0] E_valA, E_valB, E_valC;
  wire  [217:0] obsE = {E_icode, E_ifun, E_stat, E_valA, E_valB, E_valC, E_dstE, E_dstM, E_srcA, E_srcB};

  logic [217:0] expE;
  logic [63:0]  mRegs [15];
  int checks = 0;
  int failures = 0;

  decode_wb_pipe #(.DATA_W(64), .NREG(15), .RSP_INIT(RSP0)) dut (
    .clk(clk), .rst_n(rst_n), .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
    .D_valC(D_valC), .D_valP(D_valP), .D_stat(D_stat), .E_bubble(E_bubble), .E_stall(E_stall),
    .e_dstE(e_dstE), .e_valE(e_valE), .M_dstE(M_dstE), .M_valE(M_valE), .M_dstM(M_dstM),
    .m_valM(m_valM), .W_dstE(W_dstE), .W_valE(W_valE), .W_dstM(W_dstM), .W_valM(W_valM),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .E_icode(E_icode), .E_ifun(E_ifun), .E_stat(E_stat),
    .E_valA(E_valA), .E_valB(E_valB), .E_valC(E_valC), .E_dstE(E_dstE), .E_dstM(E_dstM),
    .E_srcA(E_srcA), .E_srcB(E_srcB));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] mSrcA(input logic [3:0] ic, input logic [3:0] ra);
    if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
    if (ic inside {4'h9, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] mSrcB(input logic [3:0] ic, input logic [3:0] rb);
    if (ic inside {4'h4, 4'h5, 4'h6}) return rb;
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] mDstE(input logic [3:0] ic, input logic [3:0] rb);
    if (ic inside {4'h2, 4'h3, 4'h6}) return rb;
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] mDstM(input logic [3:0] ic, input logic [3:0] ra);
    if (ic inside {4'h5, 4'hB}) return ra;
    return 4'hF;
  endfunction

  function automatic logic [63:0] mOperand(input logic [3:0] src);
`ifdef DECODE_FWD_EN
    logic [3:0]  ids  [5];
    logic [63:0] vals [5];
    ids  = '{e_dstE, M_dstM, M_dstE, W_dstM, W_dstE};
    vals = '{e_valE, m_valM, M_valE, W_valM, W_valE};
    if (src != 4'hF)
      for (int k = 0; k < 5; k++)
        if (ids[k] == src) return vals[k];
`endif
    if (src == 4'hF) return 64'd0;
    return mRegs[src];
  endfunction

  function automatic logic [217:0] mDecode();
    logic [3:0]  sa = mSrcA(D_icode, D_rA);
    logic [3:0]  sb = mSrcB(D_icode, D_rB);
    logic [63:0] va = (D_icode == 4'h7 || D_icode == 4'h8) ? D_valP : mOperand(sa);
    return {D_icode, D_ifun, D_stat, va, mOperand(sb), D_valC,
            mDstE(D_icode, D_rB), mDstM(D_icode, D_rA), sa, sb};
  endfunction

  function automatic logic [3:0] randId();
    return ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 14));
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 15; i++) mRegs[i] = (i == 4) ? RSP0 : 64'd0;
    expE = NOPV;
  endtask

  task automatic idle();
    D_icode = 4'h0; D_ifun = 4'h0; D_rA = 4'hF; D_rB = 4'hF; D_stat = 2'h0;
    D_valC = 64'd0; D_valP = 64'd0; E_bubble = 1'b0; E_stall = 1'b0;
    e_dstE = 4'hF; M_dstE = 4'hF; M_dstM = 4'hF; W_dstE = 4'hF; W_dstM = 4'hF;
    e_valE = 64'd0; M_valE = 64'd0; m_valM = 64'd0; W_valE = 64'd0; W_valM = 64'd0;
  endtask

  // One clock: predict E from pre-edge state, then retire the W-stage writes
  task automatic cycle();
    logic [217:0] nxt;
    if (!rst_n || E_bubble) nxt = NOPV;
    else if (E_stall)       nxt = expE;
    else                    nxt = mDecode();
    @(posedge clk);
    expE = nxt;
    if (rst_n) begin
      if (W_dstE != 4'hF) mRegs[W_dstE] = W_valE;
      if (W_dstM != 4'hF) mRegs[W_dstM] = W_valM;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle(); rst_n = 1'b1; #1; rst_n = 1'b0; modelReset();
    cycle(); cycle();
    checks++; if (obsE !== NOPV) begin failures++; $display("FAIL reset_e got=%h exp=%h", obsE, NOPV); end
    checks++; if (E_icode !== 4'h1) begin failures++; $display("FAIL reset_icode got=%h exp=1", E_icode); end
    checks++; if (E_dstE !== 4'hF) begin failures++; $display("FAIL reset_dstE got=%h exp=f", E_dstE); end
    checks++; if (E_valA !== 64'd0) begin failures++; $display("FAIL reset_valA got=%h exp=0", E_valA); end
    rst_n = 1'b1; D_icode = 4'h9; cycle();
    checks++; if (E_valA !== RSP0) begin failures++; $display("FAIL reset_rsp got=%h exp=%h", E_valA, RSP0); end
    checks++; if (obsE !== expE) begin failures++; $display("FAIL reset_ret got=%h exp=%h", obsE, expE); end
  endtask

  task automatic test_writeback();
    idle(); W_dstE = 4'h3; W_valE = 64'd42; cycle();
    idle(); D_icode = 4'h2; D_rA = 4'h3; D_rB = 4'h5; cycle();
    checks++; if (E_valA !== 64'd42) begin failures++; $display("FAIL wb_valA got=%h exp=2a", E_valA); end
    checks++; if (E_dstE !== 4'h5) begin failures++; $display("FAIL wb_dstE got=%h exp=5", E_dstE); end
    checks++; if (E_srcA !== 4'h3) begin failures++; $display("FAIL wb_srcA got=%h exp=3", E_srcA); end
    checks++; if (obsE !== expE) begin failures++; $display("FAIL wb_e got=%h exp=%h", obsE, expE); end
  endtask

  task automatic test_forward();
    idle(); D_icode = 4'h6; D_rA = 4'h1; D_rB = 4'h2;
    e_dstE = 4'h1; e_valE = 64'd7; M_dstE = 4'h1; M_valE = 64'd9; W_dstE = 4'h2; W_valE = 64'd11;
    cycle();
`ifdef DECODE_FWD_EN
    checks++; if (E_valA !== 64'd7) begin failures++; $display("FAIL fwd_valA got=%h exp=7", E_valA); end
    checks++; if (E_valB !== 64'd11) begin failures++; $display("FAIL fwd_valB got=%h exp=b", E_valB); end
`else
    checks++; if (E_valA !== 64'd0) begin failures++; $display("FAIL nofwd_valA got=%h exp=0", E_valA); end
    checks++; if (E_valB !== 64'd0) begin failures++; $display("FAIL nofwd_valB got=%h exp=0", E_valB); end
`endif
    checks++; if (obsE !== expE) begin failures++; $display("FAIL fwd_e got=%h exp=%h", obsE, expE); end
  endtask

  task automatic test_popq_same_id();
    idle(); D_icode = 4'hB; D_rA = 4'h4;
    W_dstE = 4'h4; W_valE = 64'd100; W_dstM = 4'h4; W_valM = 64'd200; cycle();
    checks++; if (E_dstM !== 4'h4) begin failures++; $display("FAIL pop_dstM got=%h exp=4", E_dstM); end
    checks++; if (E_srcA !== 4'h4) begin failures++; $display("FAIL pop_srcA got=%h exp=4", E_srcA); end
    idle(); D_icode = 4'h9; cycle();
    checks++; if (E_valA !== 64'd200) begin failures++; $display("FAIL pop_reg4 got=%h exp=c8", E_valA); end
  endtask

  task automatic test_call_bubble();
    idle(); D_icode = 4'h8; D_valP = 64'h20; D_valC = 64'h100; cycle();
    checks++; if (E_valA !== 64'h20) begin failures++; $display("FAIL call_valA got=%h exp=20", E_valA); end
    checks++; if (E_valB !== 64'd200) begin failures++; $display("FAIL call_valB got=%h exp=c8", E_valB); end
    checks++; if (E_dstE !== 4'h4) begin failures++; $display("FAIL call_dstE got=%h exp=4", E_dstE); end
    checks++; if (E_valC !== 64'h100) begin failures++; $display("FAIL call_valC got=%h exp=100", E_valC); end
    idle(); D_icode = 4'h6; D_rA = 4'h2; D_rB = 4'h3; E_bubble = 1'b1; cycle();
    checks++; if (obsE !== NOPV) begin failures++; $display("FAIL bubble_e got=%h exp=%h", obsE, NOPV); end
  endtask

  task automatic test_stall_reset();
    logic [217:0] held;
    idle(); D_icode = 4'h2; D_rA = 4'h3; D_rB = 4'h7; cycle();
    held = expE;
    for (int i = 0; i < 3; i++) begin
      E_stall = 1'b1; D_icode = 4'($urandom_range(0, 15)); D_rA = 4'($urandom_range(0, 15));
      D_rB = 4'($urandom_range(0, 15)); D_valC = {$urandom(), $urandom()}; D_valP = {$urandom(), $urandom()};
      cycle();
      checks++; if (obsE !== held) begin failures++; $display("FAIL stall_hold%0d got=%h exp=%h", i, obsE, held); end
    end
    W_dstE = 4'h3; W_valE = 64'd99; #2; rst_n = 1'b0; modelReset(); #1;
    checks++; if (obsE !== NOPV) begin failures++; $display("FAIL async_rst got=%h exp=%h", obsE, NOPV); end
    cycle();
    rst_n = 1'b1; idle(); D_icode = 4'h6; D_rA = 4'h3; D_rB = 4'h4; cycle();
    checks++; if (E_valA !== 64'd0) begin failures++; $display("FAIL rst_write_lost got=%h exp=0", E_valA); end
    checks++; if (E_valB !== RSP0) begin failures++; $display("FAIL rst_rsp got=%h exp=%h", E_valB, RSP0); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      D_icode = 4'($urandom_range(0, 15)); D_ifun = 4'($urandom_range(0, 15));
      D_rA = 4'($urandom_range(0, 15)); D_rB = 4'($urandom_range(0, 15));
      D_stat = 2'($urandom_range(0, 3)); D_valC = {$urandom(), $urandom()}; D_valP = {$urandom(), $urandom()};
      e_dstE = randId(); M_dstE = randId(); M_dstM = randId(); W_dstE = randId(); W_dstM = randId();
      e_valE = {$urandom(), $urandom()}; M_valE = {$urandom(), $urandom()}; m_valM = {$urandom(), $urandom()};
      W_valE = {$urandom(), $urandom()}; W_valM = {$urandom(), $urandom()};
      E_bubble = ($urandom_range(0, 9) == 0); E_stall = ($urandom_range(0, 9) == 0);
      #1;
      checks++;
      if ({d_srcA, d_srcB} !== {mSrcA(D_icode, D_rA), mSrcB(D_icode, D_rB)}) begin
        failures++; $display("FAIL rand_src n=%0d got=%h%h exp=%h%h", n, d_srcA, d_srcB,
                             mSrcA(D_icode, D_rA), mSrcB(D_icode, D_rB));
      end
      cycle();
      checks++; if (obsE !== expE) begin failures++; $display("FAIL rand_e n=%0d got=%h exp=%h", n, obsE, expE); end
    end
  endtask

  initial begin
    test_reset();
    test_writeback();
    test_forward();
    test_popq_same_id();
    test_call_bubble();
    test_stall_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
